// File: rtl/cm0_dap_ap_cdc_pkg.sv
// Shared field positions, FSM encoding and payload struct for the AP-side
// half of the DP<->AP debug CDC.
package cm0_dap_ap_cdc_pkg;

  localparam int DP2AP_W     = 38;
  localparam int AP2DP_W     = 34;

  localparam int REQ_BIT     = 0;
  localparam int WDATA_LSB   = 1;
  localparam int WDATA_W     = 32;
  localparam int REGADDR_LSB = 33;
  localparam int REGADDR_W   = 4;
  localparam int RNW_BIT     = 37;

  localparam int ACK_BIT     = 0;
  localparam int ERR_BIT     = 1;
  localparam int DATA_LSB    = 2;
  localparam int DATA_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_ACK  = 2'b10
  } ap_state_e;

  // Layout matches dp_to_ap[37:1] so the payload can be captured in one slice.
  typedef struct packed {
    logic                 rnw;
    logic [REGADDR_W-1:0] regaddr;
    logic [WDATA_W-1:0]   wdata;
  } ap_cmd_t;

endpackage

// File: rtl/cm0_dap_sync.sv
// Reset-to-0 multi-flop synchroniser; SE is routed here for scan cell
// substitution only and has no functional effect.
module cm0_dap_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic se_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic              se_unused;

  assign se_unused = se_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cm0_dap_ap_cdc.sv
// AP-side CDC half: synchronises the DP 4-phase req, runs one AP register
// access per req high phase and returns {data, err, ack} to the DP side.
module cm0_dap_ap_cdc
  import cm0_dap_ap_cdc_pkg::*;
#(
  parameter int PRESENT     = 1,
  parameter int RAR         = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic               dclk,
  input  logic               dbgreset_n,
  input  logic               SE,
  input  logic [DP2AP_W-1:0] cm0_dap_dp_to_ap,
  output logic [AP2DP_W-1:0] cm0_dap_ap_to_dp,
  output logic               ap_req_o,
  output logic               ap_rnw_o,
  output logic [3:0]         ap_regaddr_o,
  output logic [31:0]        ap_wdata_o,
  input  logic               ap_done_i,
  input  logic [31:0]        ap_rdata_i,
  input  logic               ap_err_i
);

  if (PRESENT != 0) begin : g_ap
    ap_state_e          state_q;
    logic               req_s;
    logic               req_q, ack_q, err_q;
    ap_cmd_t            cmd_q, cmd_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               cap_en, upd_en;

    cm0_dap_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk_i   (dclk),
      .rst_n_i (dbgreset_n),
      .se_i    (SE),
      .d_i     (cm0_dap_dp_to_ap[REQ_BIT]),
      .q_o     (req_s)
    );

    always_ff @(posedge dclk or negedge dbgreset_n) begin
      if (!dbgreset_n) begin
        state_q <= ST_IDLE;
        req_q   <= 1'b0;
        ack_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (req_s) begin
            state_q <= ST_BUSY;
            req_q   <= 1'b1;
          end
          ST_BUSY: if (ap_done_i) begin
            state_q <= ST_ACK;
            req_q   <= 1'b0;
            ack_q   <= 1'b1;
            err_q   <= ap_err_i;
          end
          // A req dropped during BUSY makes this a single-cycle ack.
          ST_ACK: if (!req_s) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
          end
        endcase
      end
    end

    // Payload is unsynchronised; it is only safe to sample once req_s is seen.
    assign cap_en = (state_q == ST_IDLE) && req_s;
    assign upd_en = (state_q == ST_BUSY) && ap_done_i && cmd_q.rnw;
    assign cmd_d  = cap_en ? ap_cmd_t'(cm0_dap_dp_to_ap[DP2AP_W-1:WDATA_LSB]) : cmd_q;
    assign data_d = upd_en ? ap_rdata_i : data_q;

    if (RAR != 0) begin : g_rar
      always_ff @(posedge dclk or negedge dbgreset_n) begin
        if (!dbgreset_n) begin
          cmd_q  <= '0;
          data_q <= '0;
        end else begin
          cmd_q  <= cmd_d;
          data_q <= data_d;
        end
      end
    end else begin : g_norar
      always_ff @(posedge dclk) begin
        cmd_q  <= cmd_d;
        data_q <= data_d;
      end
    end

    assign cm0_dap_ap_to_dp = {data_q, err_q, ack_q};
    assign ap_req_o         = req_q;
    assign ap_rnw_o         = cmd_q.rnw;
    assign ap_regaddr_o     = cmd_q.regaddr;
    assign ap_wdata_o       = cmd_q.wdata;
  end else begin : g_absent
    assign cm0_dap_ap_to_dp = '0;
    assign ap_req_o         = 1'b0;
    assign ap_rnw_o         = 1'b0;
    assign ap_regaddr_o     = '0;
    assign ap_wdata_o       = '0;
  end

endmodule

// File: tb/tb_cm0_dap_ap_cdc.sv
// Scoreboard bench for cm0_dap_ap_cdc (RAR=1 build): stimulus pushes the
// expected return word, a negedge monitor pops and checks it on each ack rise.
module tb_cm0_dap_ap_cdc;

  logic        dclk = 1'b0;
  logic        dbgreset_n;
  logic        SE;
  logic [37:0] dp;
  logic [33:0] ap2dp;
  logic        ap_req_o, ap_rnw_o;
  logic [3:0]  ap_regaddr_o;
  logic [31:0] ap_wdata_o;
  logic        ap_done_i, done_r, zw;
  logic [31:0] ap_rdata_i;
  logic        ap_err_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl_data;

  wire        ack  = ap2dp[0];
  wire        err  = ap2dp[1];
  wire [31:0] data = ap2dp[33:2];

  assign ap_done_i = zw ? ap_req_o : done_r;

  always #5 dclk = ~dclk;

  cm0_dap_ap_cdc #(.PRESENT(1), .RAR(1), .SYNC_STAGES(2)) dut (
    .dclk             (dclk),
    .dbgreset_n       (dbgreset_n),
    .SE               (SE),
    .cm0_dap_dp_to_ap (dp),
    .cm0_dap_ap_to_dp (ap2dp),
    .ap_req_o         (ap_req_o),
    .ap_rnw_o         (ap_rnw_o),
    .ap_regaddr_o     (ap_regaddr_o),
    .ap_wdata_o       (ap_wdata_o),
    .ap_done_i        (ap_done_i),
    .ap_rdata_i       (ap_rdata_i),
    .ap_err_i         (ap_err_i)
  );

  task automatic check(input string nm, input logic [33:0] act, input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every ack rising edge must match the oldest expected return.
  logic ack_prev = 1'b0;
  always @(negedge dclk) begin
    if (ack === 1'b1 && ack_prev !== 1'b1) begin
      if (sb_q.size() == 0) check("unexpected_ack", 1, 0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ack_data", data, e.data);
        check("ack_err", err, e.err);
      end
    end
    ack_prev = ack;
  end

  task automatic expect_ret(input logic rnw, input logic [31:0] rd, input logic er);
    exp_t e;
    if (rnw) mdl_data = rd;
    e.data = mdl_data;
    e.err  = er;
    sb_q.push_back(e);
  endtask

  // Counts edges until ap_req_o rises; req is raised just after an edge.
  task automatic wait_req(input string nm);
    int n = 0;
    do begin @(posedge dclk); #1; n++; end while (!ap_req_o && n < 12);
    check(nm, n, 3);
  endtask

  task automatic start_req(input logic rnw, input logic [3:0] addr, input logic [31:0] wd);
    @(posedge dclk); #1;
    dp = {rnw, addr, wd, 1'b1};
    wait_req("req_latency");
    check("ap_rnw", ap_rnw_o, rnw);
    check("ap_regaddr", ap_regaddr_o, addr);
    if (!rnw) check("ap_wdata", ap_wdata_o, wd);
  endtask

  task automatic drop_req(input string nm);
    int n = 0;
    dp[0] = 1'b0;
    dp[37:1] = {$urandom, $urandom};
    do begin @(posedge dclk); #1; n++; end while (ack && n < 12);
    check(nm, n, 3);
  endtask

  task automatic finish_req(input logic rnw, input logic [31:0] rd, input logic er, input int waitc);
    repeat (waitc) begin @(posedge dclk); #1; end
    check("req_held", ap_req_o, 1);
    expect_ret(rnw, rd, er);
    done_r = 1'b1; ap_rdata_i = rd; ap_err_i = er;
    @(posedge dclk); #1;
    done_r = 1'b0; ap_rdata_i = $urandom; ap_err_i = $urandom_range(0, 1);
    check("req_fall", ap_req_o, 0);
    check("ack_rise", ack, 1);
    repeat ($urandom_range(0, 3)) begin @(posedge dclk); #1; end
    check("ack_hold", ack, 1);
    drop_req("ack_fall_latency");
  endtask

  initial begin
    int n;
    dbgreset_n = 1'b0; SE = 1'b0; dp = '0; zw = 1'b0;
    done_r = 1'b0; ap_rdata_i = '0; ap_err_i = 1'b0;
    mdl_data = '0;
    repeat (3) @(posedge dclk);
    #1;
    check("rst_ap2dp", ap2dp, 34'h0);
    check("rst_ap_req", ap_req_o, 0);
    dbgreset_n = 1'b1;
    repeat (2) @(posedge dclk);

    // Plain read, then write (ap_data must keep the read value), then error read
    start_req(1'b1, 4'hC, 32'h0);
    finish_req(1'b1, 32'hDEADBEEF, 1'b0, 2);
    start_req(1'b0, 4'h4, 32'h12345678);
    finish_req(1'b0, 32'hA5A5A5A5, 1'b0, 1);
    start_req(1'b1, 4'h0, 32'h0);
    finish_req(1'b1, 32'h0BADF00D, 1'b1, 3);

    // Zero-wait AP: single-cycle ap_req_o, then no re-issue while req stays high
    zw = 1'b1; ap_rdata_i = 32'hCAFE0001; ap_err_i = 1'b0;
    expect_ret(1'b1, 32'hCAFE0001, 1'b0);
    @(posedge dclk); #1;
    dp = {1'b1, 4'h8, 32'h0, 1'b1};
    wait_req("zw_req_latency");
    @(posedge dclk); #1;
    check("zw_req_width", ap_req_o, 0);
    check("zw_ack", ack, 1);
    n = 0;
    repeat (20) begin @(posedge dclk); #1; if (ap_req_o) n++; end
    check("zw_no_reissue", n, 0);
    zw = 1'b0;
    drop_req("zw_ack_fall");

    // Protocol violation: req dropped while BUSY, done arrives late
    @(posedge dclk); #1;
    dp = {1'b1, 4'h2, 32'h0, 1'b1};
    wait_req("pv_req_latency");
    @(posedge dclk); #1;
    dp[0] = 1'b0;
    repeat (5) begin @(posedge dclk); #1; end
    check("pv_req_held", ap_req_o, 1);
    expect_ret(1'b1, 32'h5EEDBEEF, 1'b0);
    done_r = 1'b1; ap_rdata_i = 32'h5EEDBEEF; ap_err_i = 1'b0;
    @(posedge dclk); #1;
    done_r = 1'b0;
    check("pv_ack_pulse", ack, 1);
    @(posedge dclk); #1;
    check("pv_ack_gone", ack, 0);
    check("pv_req_gone", ap_req_o, 0);

    // Reset while BUSY: async clear, then a fresh access after release
    @(posedge dclk); #1;
    dp = {1'b1, 4'h6, 32'h0, 1'b1};
    wait_req("rb_req_latency");
    #2 dbgreset_n = 1'b0;
    #1;
    check("rb_req_clr", ap_req_o, 0);
    check("rb_ap2dp_clr", ap2dp, 34'h0);
    mdl_data = '0;
    @(posedge dclk); #1;
    dbgreset_n = 1'b1;
    wait_req("rb_fresh_req");
    check("rb_regaddr", ap_regaddr_o, 4'h6);
    finish_req(1'b1, 32'h600DCAFE, 1'b0, 0);

    // Randomised accesses
    for (int i = 0; i < 25; i++) begin
      logic        rnw;
      logic [3:0]  addr;
      logic [31:0] wd;
      rnw  = $urandom_range(0, 1);
      addr = $urandom_range(0, 15);
      wd   = $urandom;
      start_req(rnw, addr, wd);
      finish_req(rnw, $urandom, $urandom_range(0, 1), $urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) @(posedge dclk);
    end

    repeat (3) @(posedge dclk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
